// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment driver: double-buffered frame, per-digit
// enable/dot, fixed all-off blanking gap between slots, and a synchronised refresh tick.
module seg7_scan_driver #(
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SCAN_IN,
    input  logic        LOAD,
    input  logic [31:0] DATA_IN,
    input  logic [7:0]  EN_IN,
    input  logic [7:0]  DP_IN,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic        PEND,
    output logic        FRAME
);

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYC - 1);

    state_t      state_q, state_d;
    logic [2:0]  sync_q, sync_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  blank_cnt_q, blank_cnt_d;
    logic [31:0] act_data_q, act_data_d;
    logic [7:0]  act_en_q, act_en_d;
    logic [7:0]  act_dp_q, act_dp_d;
    logic [31:0] stg_data_q, stg_data_d;
    logic [7:0]  stg_en_q, stg_en_d;
    logic [7:0]  stg_dp_q, stg_dp_d;
    logic        pend_q, pend_d;
    logic        frame_q, frame_d;
    logic [7:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic        tick;
    logic [3:0]  nib [8];

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // sync_q[0..1] resynchronise SCAN_IN; sync_q[2] is the edge-detect history
    assign tick = sync_q[1] & ~sync_q[2];

    always_comb begin
        sync_d      = {sync_q[1:0], SCAN_IN};
        state_d     = state_q;
        idx_d       = idx_q;
        blank_cnt_d = blank_cnt_q;
        act_data_d  = act_data_q;
        act_en_d    = act_en_q;
        act_dp_d    = act_dp_q;
        stg_data_d  = stg_data_q;
        stg_en_d    = stg_en_q;
        stg_dp_d    = stg_dp_q;
        pend_d      = pend_q;
        frame_d     = 1'b0;

        case (state_q)
            ST_SHOW: begin
                if (tick) begin
                    state_d     = ST_BLANK;
                    idx_d       = idx_q + 3'd1;
                    blank_cnt_d = BLANK_LOAD;
                    if (idx_q == 3'd7 && pend_q) begin
                        act_data_d = stg_data_q;
                        act_en_d   = stg_en_q;
                        act_dp_d   = stg_dp_q;
                        pend_d     = 1'b0;
                        frame_d    = 1'b1;
                    end
                end
            end
            ST_BLANK: begin
                // ticks landing here are dropped so every slot keeps the same duty cycle
                if (blank_cnt_q == 8'd0) begin
                    state_d = ST_SHOW;
                end else begin
                    blank_cnt_d = blank_cnt_q - 8'd1;
                end
            end
            default: state_d = ST_SHOW;
        endcase

        // Evaluated after the commit so a same-cycle LOAD keeps PEND set with the new data
        if (LOAD) begin
            stg_data_d = DATA_IN;
            stg_en_d   = EN_IN;
            stg_dp_d   = DP_IN;
            pend_d     = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_nib
            assign nib[gi] = act_data_d[gi*4 +: 4];
        end
    endgenerate

    // Outputs are derived from next-state values so they register on the same edge as the FSM
    always_comb begin
        an_d  = 8'hFF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (state_d == ST_SHOW && act_en_d[idx_d]) begin
            an_d  = ~(8'd1 << idx_d);
            seg_d = seg_decode(nib[idx_d]);
            dp_d  = ~act_dp_d[idx_d];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_SHOW;
            sync_q      <= 3'b000;
            idx_q       <= 3'd0;
            blank_cnt_q <= 8'd0;
            act_data_q  <= 32'd0;
            act_en_q    <= 8'd0;
            act_dp_q    <= 8'd0;
            stg_data_q  <= 32'd0;
            stg_en_q    <= 8'd0;
            stg_dp_q    <= 8'd0;
            pend_q      <= 1'b0;
            frame_q     <= 1'b0;
            an_q        <= 8'hFF;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            idx_q       <= idx_d;
            blank_cnt_q <= blank_cnt_d;
            act_data_q  <= act_data_d;
            act_en_q    <= act_en_d;
            act_dp_q    <= act_dp_d;
            stg_data_q  <= stg_data_d;
            stg_en_q    <= stg_en_d;
            stg_dp_q    <= stg_dp_d;
            pend_q      <= pend_d;
            frame_q     <= frame_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign AN    = an_q;
    assign SEG   = seg_q;
    assign DP    = dp_q;
    assign PEND  = pend_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboarded bench for seg7_scan_driver: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_seg7_scan_driver;

    logic        CLK = 1'b0;
    logic        RST;
    logic        SCAN_IN;
    logic        LOAD;
    logic [31:0] DATA_IN;
    logic [7:0]  EN_IN;
    logic [7:0]  DP_IN;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic        DP;
    logic        PEND;
    logic        FRAME;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    localparam logic [15:0] OFF = {8'hFF, 7'h7F, 1'b1};

    typedef struct {
        int         at;
        bit         disp;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       pend;
        logic       frame;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    seg7_scan_driver #(.BLANK_CYC(16)) dut (
        .CLK(CLK), .RST(RST), .SCAN_IN(SCAN_IN), .LOAD(LOAD),
        .DATA_IN(DATA_IN), .EN_IN(EN_IN), .DP_IN(DP_IN),
        .AN(AN), .SEG(SEG), .DP(DP), .PEND(PEND), .FRAME(FRAME)
    );

    always #10 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] dec(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;  default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Expected {AN,SEG,DP} while slot i is shown for a given frame
    function automatic logic [15:0] sh(input logic [31:0] d, input logic [7:0] e,
                                       input logic [7:0] p, input int i);
        logic [7:0] a;
        if (!e[i]) return OFF;
        a = 8'd1 << i;
        return {~a, dec(d[i*4 +: 4]), ~p[i]};
    endfunction

    task automatic push(input int at, input bit disp, input logic [15:0] v,
                        input logic pend, input logic frame, input string nm);
        exp_t e;
        e.at = at; e.disp = disp; e.an = v[15:8]; e.seg = v[7:1]; e.dp = v[0];
        e.pend = pend; e.frame = frame; e.name = nm;
        sb_q.push_back(e);
    endtask

    always @(negedge CLK) begin
        while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (mon_e.at < cyc) begin
                errors++;
                $display("FAIL %s not sampled: due cycle %0d now %0d", mon_e.name, mon_e.at, cyc);
            end else if ((mon_e.disp && {AN, SEG, DP} !== {mon_e.an, mon_e.seg, mon_e.dp}) ||
                         PEND !== mon_e.pend || FRAME !== mon_e.frame) begin
                errors++;
                $display("FAIL %s cyc=%0d got AN=%h SEG=%b DP=%b PEND=%b FRAME=%b need AN=%h SEG=%b DP=%b PEND=%b FRAME=%b",
                         mon_e.name, cyc, AN, SEG, DP, PEND, FRAME,
                         mon_e.an, mon_e.seg, mon_e.dp, mon_e.pend, mon_e.frame);
            end else begin
                $display("ok   %s cyc=%0d AN=%h SEG=%b DP=%b PEND=%b FRAME=%b",
                         mon_e.name, cyc, AN, SEG, DP, PEND, FRAME);
            end
        end
    end

    task automatic load(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p,
                        input string nm);
        push(cyc + 1, 1'b0, OFF, 1'b1, 1'b0, nm);
        DATA_IN = d; EN_IN = e; DP_IN = p; LOAD = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0;
    endtask

    // One refresh slot: rising edge now, action 3 edges later, 16-cycle gap, next digit
    task automatic tick(input logic fr, input logic pd, input logic [15:0] disp, input string nm,
                        input bit dbl = 1'b0, input bit ld = 1'b0, input logic [31:0] ldd = 32'd0,
                        input logic [7:0] lde = 8'd0, input logic [7:0] ldp = 8'd0);
        int c;
        c = cyc;
        push(c + 3,  1'b1, OFF,  pd, fr,   {nm, "_blank"});
        push(c + 4,  1'b1, OFF,  pd, 1'b0, {nm, "_pulse_end"});
        push(c + 18, 1'b1, OFF,  pd, 1'b0, {nm, "_gap_end"});
        push(c + 19, 1'b1, disp, pd, 1'b0, {nm, "_show"});
        SCAN_IN = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge CLK);
            if (ld && i == 2) begin
                DATA_IN = ldd; EN_IN = lde; DP_IN = ldp; LOAD = 1'b1;
            end
            if (i == 3) LOAD = 1'b0;
            if (i == 4) SCAN_IN = 1'b0;
            if (dbl && i == 8) SCAN_IN = 1'b1;
            if (dbl && i == 12) SCAN_IN = 1'b0;
        end
    endtask

    initial begin
        int c;
        RST = 1'b1; SCAN_IN = 1'b0; LOAD = 1'b0;
        DATA_IN = 32'd0; EN_IN = 8'd0; DP_IN = 8'd0;
        @(negedge CLK);
        push(cyc + 1, 1'b1, OFF, 1'b0, 1'b0, "reset1");
        push(cyc + 2, 1'b1, OFF, 1'b0, 1'b0, "reset2");
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // First frame: staged, committed on the eighth slot
        load(32'h76543210, 8'hFF, 8'h01, "load_a");
        for (int t = 1; t <= 7; t++) tick(1'b0, 1'b1, OFF, $sformatf("prewrap%0d", t));
        tick(1'b1, 1'b0, {8'hFE, 7'b1000000, 1'b0}, "commit_a");

        // Scan through the frame; digit 0 must still be held two edges after the rise
        push(cyc + 2, 1'b1, {8'hFE, 7'b1000000, 1'b0}, 1'b0, 1'b0, "latency_hold");
        tick(1'b0, 1'b0, {8'hFD, 7'b1111001, 1'b1}, "scan1");
        for (int i = 2; i <= 7; i++)
            tick(1'b0, 1'b0, sh(32'h76543210, 8'hFF, 8'h01, i), $sformatf("scan%0d", i), (i == 3));

        // Overwrite: last load wins
        load(32'h11111111, 8'hFF, 8'h00, "load_c1");
        load(32'hAAAAAAAA, 8'hFF, 8'h00, "load_c2");
        tick(1'b1, 1'b0, {8'hFE, 7'b0001000, 1'b1}, "commit_c");
        for (int i = 1; i <= 7; i++)
            tick(1'b0, 1'b0, sh(32'hAAAAAAAA, 8'hFF, 8'h00, i), $sformatf("a_digit%0d", i));

        // Collision: load on the commit edge keeps the new data pending
        load(32'h55555555, 8'hFF, 8'h00, "load_d");
        tick(1'b1, 1'b1, {8'hFE, 7'b0010010, 1'b1}, "collide", 1'b0, 1'b1,
             32'hFFFFFFFF, 8'hFF, 8'h00);
        for (int i = 1; i <= 7; i++)
            tick(1'b0, 1'b1, sh(32'h55555555, 8'hFF, 8'h00, i), $sformatf("five%0d", i));
        tick(1'b1, 1'b0, {8'hFE, 7'b0001110, 1'b1}, "commit_f");

        // Reset during the gap after slot 4 with a frame pending
        load(32'h12345678, 8'hFF, 8'h00, "load_e");
        for (int i = 1; i <= 4; i++)
            tick(1'b0, 1'b1, sh(32'hFFFFFFFF, 8'hFF, 8'h00, i), $sformatf("f_digit%0d", i));
        c = cyc;
        push(c + 3, 1'b1, OFF, 1'b1, 1'b0, "midrst_gap");
        push(c + 6, 1'b1, OFF, 1'b0, 1'b0, "midrst");
        SCAN_IN = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge CLK);
            if (i == 4) SCAN_IN = 1'b0;
            if (i == 5) RST = 1'b1;
            if (i == 6) RST = 1'b0;
        end
        for (int t = 1; t <= 8; t++) tick(1'b0, 1'b0, OFF, $sformatf("postrst%0d", t));

        // Index restarted at 0: the next commit lands exactly on the eighth slot
        load(32'h0000000C, 8'h01, 8'h01, "load_f");
        for (int t = 1; t <= 7; t++) tick(1'b0, 1'b1, OFF, $sformatf("idxchk%0d", t));
        tick(1'b1, 1'b0, {8'hFE, 7'b1000110, 1'b0}, "commit_e");

        repeat (5) @(negedge CLK);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain left %0d need 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
